// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, reads imem over req/ready, presents instr+PC to decode over valid/ready.
// Latency 1 cycle imem_ready->instr_valid; requests launch only when the output slot is free; a WAIT request is never retracted.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic        redirect_sel,
    input  logic [63:0] redirect_base,
    input  logic [63:0] cond_addr19,
    input  logic [63:0] br_addr26
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DISCARD} state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [63:0] pc_pending_q;
    logic [63:0] stale_q;
    logic [31:0] instr_q;
    logic [63:0] instr_pc_q;
    logic        instr_valid_q;

    logic        slot_free;
    logic [63:0] offset;
    logic [63:0] target;

    assign slot_free = !instr_valid_q || id_ready;
    assign offset    = redirect_sel ? br_addr26 : cond_addr19;
    assign target    = redirect_base + {offset[61:0], 2'b00};

    always_comb begin
        imem_req = 1'b0;
        case (state_q)
            ISSUE:   imem_req = slot_free && !redirect;
            WAIT:    imem_req = 1'b1;
            DISCARD: imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    // DISCARD keeps the abandoned address on the bus until memory completes it
    assign imem_addr   = (state_q == DISCARD) ? stale_q : pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pc_pending_q  <= 64'h0;
            stale_q       <= 64'h0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 64'h0;
            instr_valid_q <= 1'b0;
        end else begin
            instr_valid_q <= instr_valid_q && !id_ready;
            if (redirect) begin
                instr_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    state_q <= ISSUE;
                    if (redirect) begin
                        pc_q <= target;
                    end
                end
                ISSUE: begin
                    if (redirect) begin
                        pc_q <= target;
                    end else if (imem_req && imem_ready) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        pc_q          <= pc_q + 64'd4;
                    end else if (imem_req) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect && imem_ready) begin
                        pc_q    <= target;
                        state_q <= ISSUE;
                    end else if (redirect) begin
                        pc_pending_q <= target;
                        stale_q      <= pc_q;
                        state_q      <= DISCARD;
                    end else if (imem_ready) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        pc_q          <= pc_q + 64'd4;
                        state_q       <= ISSUE;
                    end
                end
                DISCARD: begin
                    if (imem_ready) begin
                        pc_q    <= redirect ? target : pc_pending_q;
                        state_q <= ISSUE;
                    end else if (redirect) begin
                        pc_pending_q <= target;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
